// File: rtl/seq_branch_comparator_pkg.sv
// Shared types and helpers for the chunk-serial branch comparator.
// Build option: CMP_EARLY_EXIT_EN (consumed by the top level only).
package cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_DONE = 2'd2
   } cmp_state_e;

   localparam logic [2:0] OP_BEQ  = 3'b000;
   localparam logic [2:0] OP_BNE  = 3'b001;
   localparam logic [2:0] OP_BLT  = 3'b100;
   localparam logic [2:0] OP_BGE  = 3'b101;
   localparam logic [2:0] OP_BLTU = 3'b110;
   localparam logic [2:0] OP_BGEU = 3'b111;

   // Returns {illegal, taken}. "Not less" is written as gt|eq, which is the
   // same thing because exactly one of gt/lt/eq is set.
   function automatic logic [1:0] branch_decode(input logic [2:0] op,
                                                input logic gt,
                                                input logic lt,
                                                input logic eq);
      logic [1:0] r;
      r = 2'b00;
      case (op)
         OP_BEQ:  r = {1'b0, eq};
         OP_BNE:  r = {1'b0, ~eq};
         OP_BLT:  r = {1'b0, lt};
         OP_BGE:  r = {1'b0, gt | eq};
         OP_BLTU: r = {1'b0, lt};
         OP_BGEU: r = {1'b0, gt | eq};
         default: r = 2'b10;  // 010 / 011 are not branches
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_branch_comparator_chunk.sv
// Combinational compare of one CHUNK-bit slice. When is_msb_signed is set
// the slice holds the operand sign bit, so its MSB is flipped to turn the
// two's-complement order into a plain unsigned order.
module cmp_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             is_msb_signed,
   output logic             gt,
   output logic             lt
);

   logic [CHUNK-1:0] flip;
   logic [CHUNK-1:0] ax;
   logic [CHUNK-1:0] bx;

   // Bias the sign bit (if any) and compare unsigned.
   always_comb begin
      flip            = '0;
      flip[CHUNK-1]   = is_msb_signed;
      ax              = a ^ flip;
      bx              = b ^ flip;
      gt              = (ax > bx);
      lt              = (ax < bx);
   end

endmodule

// File: rtl/seq_branch_comparator.sv
// Chunk-serial magnitude comparator for the branch path. Compares CHUNK bits
// per cycle, MSB chunk first; the first differing chunk decides gt/lt.
// Build option: CMP_EARLY_EXIT_EN -- leave CMP as soon as a chunk differs
// instead of always walking all NCHUNK chunks. Flag values are identical.
module seq_branch_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_in_1,
   input  logic [WIDTH-1:0] i_in_2,
   input  logic             i_sign,
   input  logic [2:0]       i_op,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_gt,
   output logic             o_lt,
   output logic             o_eq,
   output logic             o_taken,
   output logic             o_illegal
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] IDX_MSB = IW'(NCHUNK - 1);

`ifdef CMP_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   if (WIDTH % CHUNK != 0) begin : g_width_chk
      $error("seq_branch_comparator: WIDTH must be a multiple of CHUNK");
   end

   cmp_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             sign_q, sign_d;
   logic [2:0]       op_q, op_d;
   logic [IW-1:0]    idx_q, idx_d;
   // sticky working flags for the operation in flight
   logic             dec_q, dec_d, gt_q, gt_d, lt_q, lt_d;
   // presented result, held after hand-off until the next one lands
   logic             rgt_q, rgt_d, rlt_q, rlt_d, req_q, req_d;
   logic             rtk_q, rtk_d, ril_q, ril_d;

   logic [NCHUNK-1:0][CHUNK-1:0] a_ch, b_ch;
   logic                         c_gt, c_lt, c_msb_signed;
   logic                         fin_eq;

   assign a_ch         = a_q;
   assign b_ch         = b_q;
   assign c_msb_signed = sign_q & (idx_q == IDX_MSB);

   cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a             (a_ch[idx_q]),
      .b             (b_ch[idx_q]),
      .is_msb_signed (c_msb_signed),
      .gt            (c_gt),
      .lt            (c_lt)
   );

   assign o_ready   = (state_q == ST_IDLE) & ~i_rst;
   assign o_valid   = (state_q == ST_DONE);
   assign o_gt      = rgt_q;
   assign o_lt      = rlt_q;
   assign o_eq      = req_q;
   assign o_taken   = rtk_q;
   assign o_illegal = ril_q;

   // Next-state: accept in IDLE, walk chunks in CMP, hold result in DONE.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sign_d  = sign_q;
      op_d    = op_q;
      idx_d   = idx_q;
      dec_d   = dec_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      rgt_d   = rgt_q;
      rlt_d   = rlt_q;
      req_d   = req_q;
      rtk_d   = rtk_q;
      ril_d   = ril_q;
      fin_eq  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               a_d     = i_in_1;
               b_d     = i_in_2;
               sign_d  = i_sign;
               op_d    = i_op;
               idx_d   = IDX_MSB;
               dec_d   = 1'b0;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               state_d = ST_CMP;
            end
         end
         ST_CMP: begin
            gt_d  = dec_q ? gt_q : c_gt;
            lt_d  = dec_q ? lt_q : c_lt;
            dec_d = dec_q | c_gt | c_lt;
            idx_d = idx_q - 1'b1;
            if ((idx_q == '0) || (EARLY_EXIT && dec_d)) begin
               fin_eq         = ~(gt_d | lt_d);
               rgt_d          = gt_d;
               rlt_d          = lt_d;
               req_d          = fin_eq;
               {ril_d, rtk_d} = branch_decode(op_q, gt_d, lt_d, fin_eq);
               idx_d          = IDX_MSB;
               state_d        = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         op_q    <= 3'b000;
         idx_q   <= IDX_MSB;
         dec_q   <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         rgt_q   <= 1'b0;
         rlt_q   <= 1'b0;
         req_q   <= 1'b0;
         rtk_q   <= 1'b0;
         ril_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sign_q  <= sign_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         dec_q   <= dec_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         rgt_q   <= rgt_d;
         rlt_q   <= rlt_d;
         req_q   <= req_d;
         rtk_q   <= rtk_d;
         ril_q   <= ril_d;
      end
   end

endmodule

// File: tb/tb_seq_branch_comparator.sv
// Scoreboard bench for seq_branch_comparator (WIDTH=32, CHUNK=8).
// Expected latencies follow CMP_EARLY_EXIT_EN when it is defined.
module tb_seq_branch_comparator;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b1;
   logic        i_sign = 1'b0;
   logic [2:0]  i_op = 3'b000;
   logic [31:0] i_in_1 = '0;
   logic [31:0] i_in_2 = '0;
   logic        o_ready, o_valid, o_gt, o_lt, o_eq, o_taken, o_illegal;

   seq_branch_comparator #(.WIDTH(32), .CHUNK(8)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_in_1    (i_in_1),
      .i_in_2    (i_in_2),
      .i_sign    (i_sign),
      .i_op      (i_op),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_gt      (o_gt),
      .o_lt      (o_lt),
      .o_eq      (o_eq),
      .o_taken   (o_taken),
      .o_illegal (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic  gt, lt, eq, taken, illegal;
      int    lat;
      string nm;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Edge counter and accept-edge stamp for latency measurement.
   always @(posedge i_clk) begin
      cyc <= cyc + 1;
      if (i_valid && o_ready) acc_cyc <= cyc + 1;
   end

   // Monitor: pop on the first cycle of each presented result, then check it holds.
   logic       seen = 1'b0;
   logic [4:0] held = '0;
   exp_t       cur;
   always @(negedge i_clk) begin
      if (i_rst) seen = 1'b0;
      else if (o_valid) begin
         if (!seen) begin
            seen = 1'b1;
            held = {o_gt, o_lt, o_eq, o_taken, o_illegal};
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected result: got flags %b with nothing outstanding", held);
            end else begin
               cur = q.pop_front();
               chk({cur.nm, " flags"}, {27'b0, held},
                   {27'b0, cur.gt, cur.lt, cur.eq, cur.taken, cur.illegal});
               chk({cur.nm, " latency"}, cyc - acc_cyc, cur.lat);
            end
         end else begin
            chk("hold stable", {27'b0, o_gt, o_lt, o_eq, o_taken, o_illegal}, {27'b0, held});
         end
      end else seen = 1'b0;
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [2:0] op, input logic g, input logic l, input logic e,
                        input logic t, input logic il, input int ld, input int le,
                        input string nm, input bit push);
      exp_t x;
      int   n;
      n = 0;
      while (!o_ready && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_ready) begin
         checks++;
         errors++;
         $display("FAIL %s: o_ready never rose (got 0 required 1)", nm);
      end
      x.gt = g; x.lt = l; x.eq = e; x.taken = t; x.illegal = il; x.nm = nm;
      x.lat = ld;
`ifdef CMP_EARLY_EXIT_EN
      x.lat = le;
`endif
      if (push) q.push_back(x);
      i_in_1  = a;
      i_in_2  = b;
      i_sign  = s;
      i_op    = op;
      i_valid = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      // operands only matter at the accept edge
      i_in_1  = ~a;
      i_in_2  = ~b;
      i_sign  = ~s;
      i_op    = ~op;
   endtask

   task automatic wait_valid(input string nm);
      int n;
      n = 0;
      while (!o_valid && n < 40) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_valid) begin
         checks++;
         errors++;
         $display("FAIL %s: o_valid never rose (got 0 required 1)", nm);
      end
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [2:0] op, input logic g, input logic l, input logic e,
                      input logic t, input logic il, input int ld, input int le,
                      input string nm);
      issue(a, b, s, op, g, l, e, t, il, ld, le, nm, 1'b1);
      wait_valid(nm);
      @(negedge i_clk);
   endtask

   initial begin
      repeat (2) @(negedge i_clk);
      chk("reset outputs", {26'b0, o_ready, o_valid, o_gt, o_lt, o_eq, o_taken, o_illegal}, 32'h0);
      i_rst = 1'b0;
      #1;
      chk("ready after reset", {31'b0, o_ready}, 32'h1);
      @(negedge i_clk);

      //     A             B             s     op      g     l     e     t     il    lat  early
      run(32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1, "blt -1<1");
      run(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, "bltu max>1");
      run(32'h12345678, 32'h12345678, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 4, "beq equal");
      run(32'h12345678, 32'h12345678, 1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4, 4, "illegal 011");
      run(32'h00000001, 32'h00000002, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4, 4, "illegal 010");
      run(32'h80000000, 32'h00000000, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, "msb chunk gt");
      run(32'h00000101, 32'h00000100, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, 4, "lsb chunk gt");
      run(32'h00000001, 32'hFFFFFFFF, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1, "bge 1>=-1");
      run(32'h00010000, 32'h00020000, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 2, "bne chunk2");
      run(32'h01FF0000, 32'h02000000, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1, "no override");
      run(32'hFF000080, 32'hFF000001, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4, "low chunk unsigned");
      run(32'h00000005, 32'h00000005, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4, 4, "bne equal");
      run(32'h00000007, 32'h00000007, 1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 4, "bge equal");

      // Back-pressure in DONE with a stray request pulse.
      i_ready = 1'b0;
      issue(32'h00000003, 32'h00000002, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, 4, "stall bge", 1'b1);
      wait_valid("stall bge");
      for (int k = 0; k < 5; k++) begin
         @(negedge i_clk);
         chk("stall ready low", {31'b0, o_ready}, 32'h0);
         chk("stall valid held", {31'b0, o_valid}, 32'h1);
         i_valid = (k == 2);
         i_in_1  = 32'h99;
         i_in_2  = 32'h11;
         i_op    = 3'b000;
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge i_clk);
      chk("handoff valid low", {31'b0, o_valid}, 32'h0);
      chk("handoff ready high", {31'b0, o_ready}, 32'h1);
      chk("handoff flags kept", {27'b0, o_gt, o_lt, o_eq, o_taken, o_illegal}, 32'b10010);
      issue(32'h00000010, 32'h00000020, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 4, "after handoff", 1'b1);
      chk("accepted edge after handoff", acc_cyc, cyc);
      wait_valid("after handoff");
      @(negedge i_clk);

      // Reset on the second CMP cycle; this operation must never surface.
      issue(32'h00000022, 32'h00000011, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, 4, "aborted", 1'b0);
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      chk("abort outputs zero", {26'b0, o_ready, o_valid, o_gt, o_lt, o_eq, o_taken, o_illegal}, 32'h0);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      chk("ready after abort", {31'b0, o_ready}, 32'h1);
      @(negedge i_clk);
      run(32'h00000005, 32'h00000007, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 4, "post-abort blt");

      repeat (4) @(negedge i_clk);
      chk("scoreboard drained", q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
